// File: rtl/fetch_decode_if.sv
// rtl/fetch_decode_if.sv - PC, instruction memory, stall/completion and decoded-field bundle
// between the CHIP-8 front end (master) and its environment (slave).
interface fetch_decode_if;
    logic [15:0] pc_rd;
    logic [15:0] pc_wr;
    logic        pc_en;
    logic        imem_en;
    logic [11:0] imem_addr;
    logic [15:0] imem_data;
    logic        stall;
    logic        exec_done;
    logic        issue;
    logic [5:0]  decode;
    logic [3:0]  x;
    logic [3:0]  y;
    logic [3:0]  n;
    logic [7:0]  val;
    logic [11:0] addr;
    logic        illegal;

    modport master (
        input  pc_rd, imem_data, stall, exec_done,
        output pc_wr, pc_en, imem_en, imem_addr, issue, decode, x, y, n, val, addr, illegal
    );

    modport slave (
        output pc_rd, imem_data, stall, exec_done,
        input  pc_wr, pc_en, imem_en, imem_addr, issue, decode, x, y, n, val, addr, illegal
    );
endinterface

// File: rtl/fetch_decode.sv
// rtl/fetch_decode.sv - CHIP-8 fetch/decode front end: one instruction in flight,
// PC advanced in DECODE, fields held until the next DECODE.
module fetch_decode (
    input  logic          clk,
    input  logic          rst,
    fetch_decode_if.master bus
);
    typedef enum logic [2:0] {FETCH, WAIT, DECODE, ISSUE, EXEC} state_t;

    state_t      state;
    logic [15:0] ir;
    logic [5:0]  code;

    // The read strobe must appear in the FETCH cycle itself, so it follows stall directly.
    assign bus.imem_en   = (state == FETCH) && !bus.stall && !rst;
    assign bus.imem_addr = bus.imem_en ? bus.pc_rd[11:0] : 12'h000;

    always_comb begin
        code = 6'd0;
        case (ir[15:12])
            4'h0: begin
                if (ir[11:0] == 12'h0E0)      code = 6'd1;
                else if (ir[11:0] == 12'h0EE) code = 6'd2;
            end
            4'h1: code = 6'd3;
            4'h2: code = 6'd4;
            4'h3: code = 6'd5;
            4'h4: code = 6'd6;
            4'h5: if (ir[3:0] == 4'h0) code = 6'd7;
            4'h6: code = 6'd8;
            4'h7: code = 6'd9;
            4'h8: begin
                if (ir[3:0] <= 4'h7)      code = 6'd10 + {2'b00, ir[3:0]};
                else if (ir[3:0] == 4'hE) code = 6'd18;
            end
            4'h9: if (ir[3:0] == 4'h0) code = 6'd19;
            4'hA: code = 6'd20;
            4'hB: code = 6'd21;
            4'hC: code = 6'd22;
            4'hD: code = 6'd23;
            4'hE: begin
                case (ir[7:0])
                    8'h9E:   code = 6'd24;
                    8'hA1:   code = 6'd25;
                    default: code = 6'd0;
                endcase
            end
            default: begin
                // Code 31 is reserved, so Fx29 jumps straight to 32.
                case (ir[7:0])
                    8'h07:   code = 6'd26;
                    8'h0A:   code = 6'd27;
                    8'h15:   code = 6'd28;
                    8'h18:   code = 6'd29;
                    8'h1E:   code = 6'd30;
                    8'h29:   code = 6'd32;
                    8'h33:   code = 6'd33;
                    8'h55:   code = 6'd34;
                    8'h65:   code = 6'd35;
                    default: code = 6'd0;
                endcase
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FETCH;
            ir          <= 16'h0000;
            bus.pc_wr   <= 16'h0000;
            bus.pc_en   <= 1'b0;
            bus.issue   <= 1'b0;
            bus.illegal <= 1'b0;
            bus.decode  <= 6'd0;
            bus.x       <= 4'h0;
            bus.y       <= 4'h0;
            bus.n       <= 4'h0;
            bus.val     <= 8'h00;
            bus.addr    <= 12'h000;
        end else begin
            bus.pc_en   <= 1'b0;
            bus.issue   <= 1'b0;
            bus.illegal <= 1'b0;
            case (state)
                FETCH: begin
                    if (!bus.stall) state <= WAIT;
                end
                WAIT: begin
                    ir        <= bus.imem_data;
                    bus.pc_en <= 1'b1;
                    bus.pc_wr <= bus.pc_rd + 16'd1;
                    state     <= DECODE;
                end
                DECODE: begin
                    bus.decode <= code;
                    // Bnnn jumps relative to V0, which execute reads through its vx port.
                    bus.x      <= (ir[15:12] == 4'hB) ? 4'h0 : ir[11:8];
                    bus.y      <= ir[7:4];
                    bus.n      <= ir[3:0];
                    bus.val    <= ir[7:0];
                    bus.addr   <= ir[11:0];
                    if (code == 6'd0) begin
                        bus.illegal <= 1'b1;
                        state       <= FETCH;
                    end else begin
                        bus.issue <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= bus.exec_done ? FETCH : EXEC;
                end
                EXEC: begin
                    if (bus.exec_done) state <= FETCH;
                end
                default: state <= FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_decode.sv
// tb/tb_fetch_decode.sv - directed and randomized bench for fetch_decode against a
// pattern-table opcode model and a simple external PC.
module tb_fetch_decode;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_decode_if bus();
    fetch_decode dut (.clk(clk), .rst(rst), .bus(bus));

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0] mask;
        logic [15:0] match;
        int          code;
    } pat_t;
    pat_t pats[$];

    logic [15:0] pc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic add_pat(input logic [15:0] mask, input logic [15:0] match, input int code);
        pat_t p;
        p.mask  = mask;
        p.match = match;
        p.code  = code;
        pats.push_back(p);
    endtask

    task automatic build_table();
        add_pat(16'hFFFF, 16'h00E0, 1);
        add_pat(16'hFFFF, 16'h00EE, 2);
        add_pat(16'hF000, 16'h1000, 3);
        add_pat(16'hF000, 16'h2000, 4);
        add_pat(16'hF000, 16'h3000, 5);
        add_pat(16'hF000, 16'h4000, 6);
        add_pat(16'hF00F, 16'h5000, 7);
        add_pat(16'hF000, 16'h6000, 8);
        add_pat(16'hF000, 16'h7000, 9);
        for (int i = 0; i < 8; i++) add_pat(16'hF00F, 16'h8000 | 16'(i), 10 + i);
        add_pat(16'hF00F, 16'h800E, 18);
        add_pat(16'hF00F, 16'h9000, 19);
        add_pat(16'hF000, 16'hA000, 20);
        add_pat(16'hF000, 16'hB000, 21);
        add_pat(16'hF000, 16'hC000, 22);
        add_pat(16'hF000, 16'hD000, 23);
        add_pat(16'hF0FF, 16'hE09E, 24);
        add_pat(16'hF0FF, 16'hE0A1, 25);
        add_pat(16'hF0FF, 16'hF007, 26);
        add_pat(16'hF0FF, 16'hF00A, 27);
        add_pat(16'hF0FF, 16'hF015, 28);
        add_pat(16'hF0FF, 16'hF018, 29);
        add_pat(16'hF0FF, 16'hF01E, 30);
        add_pat(16'hF0FF, 16'hF029, 32);
        add_pat(16'hF0FF, 16'hF033, 33);
        add_pat(16'hF0FF, 16'hF055, 34);
        add_pat(16'hF0FF, 16'hF065, 35);
    endtask

    function automatic int ref_code(input logic [15:0] op);
        foreach (pats[i]) if ((op & pats[i].mask) == pats[i].match) return pats[i].code;
        return 0;
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_pc_en"},     32'(bus.pc_en),     0);
        chk({tag, "_imem_en"},   32'(bus.imem_en),   0);
        chk({tag, "_imem_addr"}, 32'(bus.imem_addr), 0);
        chk({tag, "_issue"},     32'(bus.issue),     0);
        chk({tag, "_illegal"},   32'(bus.illegal),   0);
        chk({tag, "_pc_wr"},     32'(bus.pc_wr),     0);
        chk({tag, "_decode"},    32'(bus.decode),    0);
        chk({tag, "_x"},         32'(bus.x),         0);
        chk({tag, "_y"},         32'(bus.y),         0);
        chk({tag, "_n"},         32'(bus.n),         0);
        chk({tag, "_val"},       32'(bus.val),       0);
        chk({tag, "_addr"},      32'(bus.addr),      0);
    endtask

    // Entered in a FETCH cycle after its falling edge; returns in the next FETCH cycle.
    task automatic run_instr(input logic [15:0] op, input int delay);
        int          exp;
        logic [15:0] nxt;
        logic [3:0]  exp_x;
        exp   = ref_code(op);
        nxt   = pc + 16'd1;
        exp_x = (op[15:12] == 4'hB) ? 4'h0 : op[11:8];
        bus.imem_data = op;
        bus.stall     = 1'b0;
        bus.exec_done = 1'b0;
        bus.pc_rd     = pc;
        #1;
        chk("t0_imem_en",   32'(bus.imem_en),   1);
        chk("t0_imem_addr", 32'(bus.imem_addr), 32'(pc[11:0]));
        chk("t0_issue",     32'(bus.issue),     0);
        @(negedge clk); #1;
        chk("t1_imem_en",   32'(bus.imem_en),   0);
        chk("t1_imem_addr", 32'(bus.imem_addr), 0);
        chk("t1_issue",     32'(bus.issue),     0);
        @(negedge clk); #1;
        chk("t2_pc_en", 32'(bus.pc_en), 1);
        chk("t2_pc_wr", 32'(bus.pc_wr), 32'(nxt));
        chk("t2_issue", 32'(bus.issue), 0);
        pc = nxt;
        @(negedge clk);
        bus.pc_rd     = pc;
        bus.exec_done = (delay == 0);
        #1;
        chk("t3_pc_en", 32'(bus.pc_en), 0);
        if (exp == 0) begin
            chk("ill_pulse",   32'(bus.illegal), 1);
            chk("ill_issue",   32'(bus.issue),   0);
            chk("ill_decode",  32'(bus.decode),  0);
            chk("ill_refetch", 32'(bus.imem_en), 1);
            bus.exec_done = 1'b0;
            return;
        end
        chk("t3_issue",   32'(bus.issue),   1);
        chk("t3_illegal", 32'(bus.illegal), 0);
        chk("t3_decode",  32'(bus.decode),  32'(exp));
        chk("t3_x",       32'(bus.x),       32'(exp_x));
        chk("t3_y",       32'(bus.y),       32'(op[7:4]));
        chk("t3_n",       32'(bus.n),       32'(op[3:0]));
        chk("t3_val",     32'(bus.val),     32'(op[7:0]));
        chk("t3_addr",    32'(bus.addr),    32'(op[11:0]));
        chk("t3_imem_en", 32'(bus.imem_en), 0);
        for (int k = 1; k <= delay; k++) begin
            @(negedge clk);
            bus.exec_done = (k == delay);
            bus.stall     = 1'($urandom_range(0, 1));
            #1;
            chk("ex_issue",   32'(bus.issue),   0);
            chk("ex_imem_en", 32'(bus.imem_en), 0);
            chk("ex_decode",  32'(bus.decode),  32'(exp));
            chk("ex_x",       32'(bus.x),       32'(exp_x));
            chk("ex_val",     32'(bus.val),     32'(op[7:0]));
        end
        @(negedge clk);
        bus.exec_done = 1'b0;
        bus.stall     = 1'b0;
    endtask

    logic [15:0] rop;
    int          pick;

    initial begin
        build_table();
        rst           = 1'b1;
        bus.stall     = 1'b0;
        bus.exec_done = 1'b0;
        bus.imem_data = 16'h0000;
        bus.pc_rd     = 16'h0000;
        pc            = 16'h0100;
        @(negedge clk);
        @(negedge clk); #1;
        chk_reset_outputs("rst");
        rst = 1'b0;

        run_instr(16'h6A2F, 0);
        run_instr(16'h8124, 0);
        run_instr(16'h812E, 1);
        run_instr(16'h00EE, 0);
        run_instr(16'hB345, 2);
        run_instr(16'h0123, 0);
        run_instr(16'h8128, 0);

        for (int i = 0; i < 5; i++) begin
            bus.stall = 1'b1;
            #1;
            chk("stall_imem_en",   32'(bus.imem_en),   0);
            chk("stall_imem_addr", 32'(bus.imem_addr), 0);
            @(negedge clk);
        end
        run_instr(16'hD125, 3);

        pc = 16'hFFFF;
        run_instr(16'hA123, 0);
        chk("wrap_pc", 32'(pc), 0);

        // Reset while in EXEC with exec_done pending.
        bus.imem_data = 16'h7123;
        bus.pc_rd     = pc;
        @(negedge clk);
        @(negedge clk);
        pc = pc + 16'd1;
        @(negedge clk);
        bus.pc_rd = pc;
        @(negedge clk);
        rst           = 1'b1;
        bus.exec_done = 1'b1;
        #1;
        chk("rstx_issue", 32'(bus.issue), 0);
        chk("rstx_pc_en", 32'(bus.pc_en), 0);
        @(negedge clk); #1;
        chk_reset_outputs("rstx");
        rst           = 1'b0;
        bus.exec_done = 1'b0;
        run_instr(16'h3C44, 0);

        for (int i = 0; i < 60; i++) begin
            pick = int'($urandom_range(0, 2));
            if (pick == 0) begin
                rop = 16'($urandom);
            end else begin
                pick = int'($urandom_range(0, pats.size() - 1));
                rop  = (16'($urandom) & ~pats[pick].mask) | pats[pick].match;
            end
            if ($urandom_range(0, 7) == 0) pc = 16'($urandom);
            if ($urandom_range(0, 5) == 0) begin
                bus.stall = 1'b1;
                #1;
                chk("rnd_stall", 32'(bus.imem_en), 0);
                @(negedge clk);
            end
            run_instr(rop, int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        bad++;
        $display("FAIL timeout observed=running expected=finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fetch_decode.md
# fetch_decode

Instruction front end of the CHIP-8 core: fetches 16-bit opcodes from instruction memory at the current PC and advances the PC. Decodes each opcode into the 6-bit operation code and operand fields consumed by the execute stage. Issues one instruction at a time and waits for the execute stage's completion pulse before fetching the next, so fetch and execute never write the PC in the same cycle.

## Interface
- PC_RESET, 16'h0100: informational word address of the program start; the PC register itself lives outside this block.
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- pc_rd  in  16  current PC (word address)
- pc_wr  out  16  next PC value (pc_rd + 1)
- pc_en  out  1  one-cycle PC write strobe
- imem_en  out  1  instruction read strobe
- imem_addr  out  12  instruction word address, pc_rd[11:0]
- imem_data  in  16  opcode, valid the cycle after imem_en
- stall  in  1  hold off new fetches while high
- exec_done  in  1  execute stage finished the issued instruction
- issue  out  1  one-cycle pulse: decode/x/y/n/val/addr valid
- decode  out  6  operation code (0 = none/illegal)
- x, y, n  out  4 each  opcode nibbles [11:8], [7:4], [3:0]
- val  out  8  opcode[7:0]
- addr  out  12  opcode[11:0]
- illegal  out  1  one-cycle pulse on an unrecognised opcode

## Operation
- States: FETCH, WAIT, DECODE, ISSUE, EXEC.
  - FETCH: if stall=0, assert imem_en and go to WAIT; otherwise stay in FETCH with imem_en=0.
  - WAIT: latch imem_data into the internal instruction register.
  - DECODE: register all fields and pulse pc_en with pc_wr = pc_rd + 1. An illegal opcode goes to FETCH with an illegal pulse; any other opcode goes to ISSUE.
  - ISSUE: pulse issue. Go to FETCH if exec_done=1 this cycle, otherwise to EXEC.
  - EXEC: wait for exec_done=1, then go to FETCH.
- Decode map (opcode -> decode):
  - 00E0->1, 00EE->2, 1nnn->3, 2nnn->4, 3xkk->5, 4xkk->6, 5xy0->7, 6xkk->8, 7xkk->9.
  - 8xy0..8xy7->10..17, 8xyE->18, 9xy0->19, Annn->20, Bnnn->21, Cxkk->22, Dxyn->23, Ex9E->24, ExA1->25.
  - Fx07->26, Fx0A->27, Fx15->28, Fx18->29, Fx1E->30, Fx29->32, Fx33->33, Fx55->34, Fx65->35.
  - Code 31 is reserved and never emitted.
- Everything else is illegal, including 0nnn other than 00E0/00EE, 5xyN and 9xyN with N≠0, and 8xy8..8xyD/8xyF.
- For Bnnn, x is forced to 0 so the execute stage reads V0 on its vx port; all other fields are raw nibbles.
- The PC is incremented before issue. Execute-stage skips therefore write pc_rd+1 on top of the already-advanced PC, and jumps overwrite it.
- Fields hold their value from DECODE until the next DECODE; the execute stage may sample them at any point until exec_done.
- Illegal opcodes: decode=0, issue is not pulsed, the PC still advances, and fetch resumes.

## Timing
- Reset values: state FETCH; pc_en, imem_en, issue, illegal = 0; pc_wr, imem_addr, decode, x, y, n, val, addr, instruction register = 0.
- Steady state with no stall and exec_done in the ISSUE cycle: 4 cycles per instruction.
  - t0 imem_en, t1 data latched, t2 pc_en, t3 issue, t4 next imem_en.
- Each extra cycle before exec_done adds one cycle. exec_done outside ISSUE/EXEC is ignored.
- stall is sampled only in FETCH; asserting it in other states has no effect until the block returns to FETCH.
- imem_addr is driven only while imem_en=1, and is 0 otherwise.
- rst in any state, including mid-EXEC with exec_done pending:
  - next cycle is FETCH with all outputs at reset values;
  - the in-flight instruction is discarded, and no pc_en or issue occurs in the reset cycle.
- pc_wr is 16 bits and wraps: pc_rd=16'hFFFF gives pc_wr=16'h0000.

## Test plan
- Reset, then pc_rd=16'h0100, imem_data=16'h6A2F, exec_done in the ISSUE cycle:
  - imem_addr=12'h100 at t0, pc_en with pc_wr=16'h0101 at t2;
  - issue at t3 with decode=8, x=4'hA, val=8'h2F;
  - next imem_en at t4.
- Opcode 16'h8124: decode=14, x=1, y=2. Opcode 16'h812E: decode=18. Opcode 16'h00EE: decode=2.
- Opcode 16'hB345: decode=21, x=0, addr=12'h345.
- Opcode 16'h0123, then 16'h8128: for each, illegal pulses once, decode=0, no issue, pc_en still pulses, and the next fetch follows immediately.
- stall=1 for 5 cycles in FETCH: no imem_en during the stall. exec_done held low for 3 cycles after issue: decode fields stay stable and no fetch occurs until exec_done.
- rst asserted in EXEC with exec_done=1 in the same cycle: next cycle is FETCH, all outputs are 0, and no issue follows until a new fetch completes.
